spi_regfile_peripheral: RTL and testbench
=========================================

# spi_regfile_peripheral

Parametrised SPI (mode 0) target that fronts a configurable bank of control registers, supporting both writes and read-back over CIPO. It is the next generation of the project's write-only SPI configuration peripheral. All SPI inputs are oversampled in the system clock domain, and every register is written synchronously to that domain. Downstream blocks (output enables, PWM enables, duty cycles) consume the flat register bus and the per-write strobe.

## Interface
- NUM_REGS, 8: number of DATA_W-bit registers, 1..2^ADDR_W
- ADDR_W, 7: address field width in the frame
- DATA_W, 8: register and data-field width
- SYNC_STAGES, 2: synchronizer depth on sclk/copi/ncs, ≥2
- clk  in  1  system clock; one clock only
- rst_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock, idle low, async to clk
- copi  in  1  SPI data in, sampled on sclk rise
- ncs  in  1  SPI chip select, active low
- cipo  out  1  SPI data out, changes after sclk fall
- cipo_oe  out  1  output enable for cipo pad, high while selected
- regs_o  out  NUM_REGS*DATA_W  register bank, reg k at [k*DATA_W +: DATA_W]
- wr_pulse_o  out  1  one-clk strobe on committed write
- wr_addr_o  out  ADDR_W  address of last committed write

## Operation
- Frame (FRAME_W = 1+ADDR_W+DATA_W bits, MSB first): R/W bit (1 = write, 0 = read), then address, then data.
- States:
  - IDLE: wait for synced ncs low → ADDR.
  - ADDR: shift 1+ADDR_W bits; on the last one → DATA.
  - DATA: shift DATA_W bits; on the last one → DONE.
  - DONE: ignore all further sclk edges.
- Synced ncs high returns the FSM to IDLE from any state.
- Write: after the final data bit, if addr < NUM_REGS, update the register, pulse wr_pulse_o for one cycle and load wr_addr_o. Out-of-range addresses are silently dropped: no pulse, no change.
- Read: when the address completes, load the selected register into the output shifter (zeros if addr ≥ NUM_REGS). cipo presents the MSB immediately and shifts on each subsequent synced sclk fall. Data bits received during a read are ignored. A read never changes the registers.
- cipo = 0 whenever not in DATA of a read. cipo_oe = ~ncs_sync.
- Aborted frame (ncs rises before FRAME_W bits): discard, no write, no pulse.
- Over-length frame: the first FRAME_W bits take effect; the extras are ignored (DONE).
- Reset, asynchronous: regs_o, wr_pulse_o, wr_addr_o, cipo, cipo_oe, shifters and bit counter → 0; synchronizers → idle values (sclk 0, ncs 1); FSM → IDLE.
- Reset asserted mid-frame: the frame is lost. If ncs is still low after release, IDLE waits for ncs high before accepting a new frame.

## Timing
- Edge detection uses the last two synchronized samples. An sclk edge is acted on SYNC_STAGES+1 clk cycles after the pin transition.
- Write commit: registers and wr_pulse_o update on the clk edge after the last data-bit rise is detected. Latency = SYNC_STAGES+2 clk from the pin edge.
- Requirement: f_clk ≥ 8·f_sclk. ncs setup/hold to sclk ≥ 2 clk.
- Same-cycle synced ncs rise and sclk rise: ncs wins and the sclk edge is ignored. A frame whose last bit coincides with ncs rising is therefore aborted.
- Back-to-back frames: ncs must stay high ≥ SYNC_STAGES+1 clk between frames.

## Structure
- Package spi_regfile_pkg: state enum (IDLE, ADDR, DATA, DONE), R/W bit encoding, FRAME_W computation function.
- Sub-module spi_sync_edge: SYNC_STAGES flop synchronizer plus rise/fall detect, with a reset-value parameter. Instantiated for sclk and ncs; copi uses the same module with its edge outputs unused.

## Test plan
- Write 0xA5 to addr 2 (frame 0x82A5) → regs_o[23:16]=0xA5, one wr_pulse_o with wr_addr_o=2, other registers 0.
- After that write, read addr 2 (frame 0x0200) → cipo shifts 1010_0101 on data-phase sclk rises; regs unchanged; cipo_oe tracks ncs.
- Write 0x3C to addr 9 (frame 0x893C, NUM_REGS=8) → no pulse, all registers unchanged; a read of addr 9 returns 0x00.
- ncs raised after 10 bits of frame 0x84FF → no write. A following full frame 0x8411 → reg4=0x11.
- 20-bit frame starting 0x8177 → reg1=0x77 exactly once, trailing bits ignored.
- rst_n pulsed low after 12 bits of a write with ncs held low → all outputs 0, no write. Once ncs cycles high then low, the next frame 0x8342 → reg3=0x42.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// rtl/spi_regfile_pkg.sv - shared types and frame helpers for the SPI register-file target
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detect on the last two samples
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// rtl/spi_regfile_peripheral.sv - SPI mode-0 target with read/write access to a register bank
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse_o,
  output logic [ADDR_W-1:0]          wr_addr_o
);

  import spi_regfile_pkg::*;

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0]  LAST_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  FIRST_DATA = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0]  LAST_DATA  = CNT_W'(FRAME_W - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise_unused, ncs_fall_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .dout (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ncs),
    .dout (ncs_s),
    .rise (ncs_rise_unused),
    .fall (ncs_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (copi),
    .dout (copi_s),
    .rise (copi_rise_unused),
    .fall (copi_fall_unused)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W:0]    hdr_q;
  logic [ADDR_W:0]    hdr_next;
  logic [DATA_W-1:0]  data_sh;
  logic [DATA_W-1:0]  out_sh;
  logic [DATA_W-1:0]  rd_data;
  logic               commit_q;
  logic               armed_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic               addr_in_range;
  logic               is_read;

  assign hdr_next      = {hdr_q[ADDR_W-1:0], copi_s};
  assign addr_in_range = {1'b0, hdr_q[ADDR_W-1:0]} < NUM_REGS_L;
  assign is_read       = (hdr_q[ADDR_W] == RW_READ);

  // Reads select on the address including the bit arriving this cycle.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hdr_next[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs_o[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // armed_q keeps a frame cut by reset from resuming until ncs is seen high.
  always_comb begin
    state_d = state_q;
    if (ncs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (armed_q) state_d = ST_ADDR;
        ST_ADDR: if (sclk_rise && cnt_q == LAST_ADDR) state_d = ST_DATA;
        ST_DATA: if (sclk_rise && cnt_q == LAST_DATA) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hdr_q      <= '0;
      data_sh    <= '0;
      out_sh     <= '0;
      commit_q   <= 1'b0;
      armed_q    <= 1'b0;
      settle_q   <= '0;
      regs_o     <= '0;
      wr_pulse_o <= 1'b0;
      wr_addr_o  <= '0;
    end else begin
      settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      commit_q   <= 1'b0;
      wr_pulse_o <= 1'b0;

      if (settle_q[SYNC_STAGES-1] && ncs_s) armed_q <= 1'b1;

      if (state_q == ST_IDLE && state_d == ST_ADDR) begin
        cnt_q   <= '0;
        hdr_q   <= '0;
        data_sh <= '0;
        out_sh  <= '0;
      end

      if (!ncs_s && sclk_rise) begin
        if (state_q == ST_ADDR) begin
          hdr_q <= hdr_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ADDR) out_sh <= (hdr_next[ADDR_W] == RW_READ) ? rd_data : '0;
        end else if (state_q == ST_DATA) begin
          data_sh <= {data_sh[DATA_W-2:0], copi_s};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_DATA && !is_read && addr_in_range) commit_q <= 1'b1;
        end
      end

      // The fall closing the last address bit must not shift: the MSB is still owed.
      if (!ncs_s && sclk_fall && state_q == ST_DATA && is_read && cnt_q > FIRST_DATA)
        out_sh <= {out_sh[DATA_W-2:0], 1'b0};

      if (commit_q) begin
        wr_pulse_o <= 1'b1;
        wr_addr_o  <= hdr_q[ADDR_W-1:0];
        for (int k = 0; k < NUM_REGS; k++) begin
          if (hdr_q[ADDR_W-1:0] == ADDR_W'(k)) regs_o[k*DATA_W +: DATA_W] <= data_sh;
        end
      end
    end
  end

  assign cipo    = (state_q == ST_DATA && is_read) ? out_sh[DATA_W-1] : 1'b0;
  assign cipo_oe = ~ncs_s;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb/tb_spi_regfile_peripheral.sv - randomized self-checking bench with a transaction-level register model
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS    = 8;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        ncs = 1'b1;
  logic        cipo, cipo_oe, wr_pulse_o;
  logic [63:0] regs_o;
  logic [6:0]  wr_addr_o;

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_o    (regs_o),
    .wr_pulse_o(wr_pulse_o),
    .wr_addr_o (wr_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t        cmd_q[$];
  int          cmd_rd = 0;
  int          cyc = 0;
  logic [7:0]  model_regs [8];
  logic [6:0]  model_waddr = '0;
  logic        exp_pulse = 1'b0;
  logic [63:0] model_flat;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a committed write lands exactly SYNC_STAGES+2 clocks after its last data-bit pin rise.
  initial begin
    for (int k = 0; k < 8; k++) model_regs[k] = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) model_regs[k] = 8'h00;
        model_waddr = '0;
        exp_pulse   = 1'b0;
      end else begin
        cyc++;
        exp_pulse = 1'b0;
        if (cmd_rd < cmd_q.size() && cmd_q[cmd_rd].cyc == cyc) begin
          model_regs[cmd_q[cmd_rd].addr] = cmd_q[cmd_rd].data;
          model_waddr = 7'(cmd_q[cmd_rd].addr);
          exp_pulse   = 1'b1;
          cmd_rd++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) model_flat[k*8 +: 8] = model_regs[k];
      check("regs_o", regs_o, model_flat);
      check("wr_pulse_o", {63'd0, wr_pulse_o}, {63'd0, exp_pulse});
      check("wr_addr_o", {57'd0, wr_addr_o}, {57'd0, model_waddr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // live=0 means the target is expected to ignore the frame entirely.
  task automatic send_frame(input logic [15:0] frame, input int n, input logic [7:0] extra,
                            input bit live, input bit raise_ncs, output logic [7:0] rd);
    logic       rw, b, exp_bit;
    int         addr;
    logic [7:0] exp_byte;
    cmd_t       c;
    rd       = 8'h00;
    rw       = frame[15];
    addr     = int'(frame[14:8]);
    exp_byte = (addr < NUM_REGS) ? model_regs[addr] : 8'h00;
    ncs = 1'b0;
    tick(4);
    check("cipo_oe_sel", {63'd0, cipo_oe}, 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i < 16) b = frame[15-i];
      else        b = extra[23-i];
      copi = b;
      tick(3);
      exp_bit = (live && !rw && i >= 8 && i < 16) ? exp_byte[15-i] : 1'b0;
      check("cipo", {63'd0, cipo}, {63'd0, exp_bit});
      if (i >= 8 && i < 16) rd[15-i] = cipo;
      sclk = 1'b1;
      if (live && rw && i == 15 && addr < NUM_REGS) begin
        c.cyc  = cyc + SYNC_STAGES + 2;
        c.addr = addr;
        c.data = frame[7:0];
        cmd_q.push_back(c);
      end
      tick(5);
      sclk = 1'b0;
      tick(2);
    end
    if (raise_ncs) begin
      tick(2);
      ncs = 1'b1;
      tick(6);
      check("cipo_oe_idle", {63'd0, cipo_oe}, 64'd0);
    end
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] frame;
    int          kind, n;
    rst_n = 1'b0;
    tick(4);
    check("reset_regs", regs_o, 64'h0);
    check("reset_cipo", {63'd0, cipo}, 64'd0);
    check("reset_cipo_oe", {63'd0, cipo_oe}, 64'd0);
    check("reset_pulse", {63'd0, wr_pulse_o}, 64'd0);
    rst_n = 1'b1;
    tick(6);

    send_frame(16'h82A5, 16, 8'h00, 1, 1, rd);
    check("wr_a5_regs", regs_o, 64'h0000_0000_00A5_0000);
    check("wr_a5_addr", {57'd0, wr_addr_o}, 64'd2);
    check("model_reg2", {56'd0, model_regs[2]}, 64'hA5);

    send_frame(16'h0200, 16, 8'h00, 1, 1, rd);
    check("rd_addr2", {56'd0, rd}, 64'hA5);
    check("rd_no_change", regs_o, 64'h0000_0000_00A5_0000);

    send_frame(16'h893C, 16, 8'h00, 1, 1, rd);
    check("oor_write", regs_o, 64'h0000_0000_00A5_0000);
    send_frame(16'h0900, 16, 8'h00, 1, 1, rd);
    check("oor_read", {56'd0, rd}, 64'h00);

    send_frame(16'h84FF, 10, 8'h00, 1, 1, rd);
    check("abort_write", regs_o, 64'h0000_0000_00A5_0000);
    send_frame(16'h8411, 16, 8'h00, 1, 1, rd);
    check("wr_reg4", regs_o, 64'h0000_0011_00A5_0000);

    send_frame(16'h8177, 20, 8'hA0, 1, 1, rd);
    check("overlen_reg1", regs_o, 64'h0000_0011_00A5_7700);

    send_frame(16'h8355, 12, 8'h00, 1, 0, rd);
    rst_n = 1'b0;
    tick(3);
    check("midrst_regs", regs_o, 64'h0);
    check("midrst_addr", {57'd0, wr_addr_o}, 64'd0);
    rst_n = 1'b1;
    tick(4);
    send_frame(16'h8366, 16, 8'h00, 0, 1, rd);
    check("no_resume_after_rst", regs_o, 64'h0);
    send_frame(16'h8342, 16, 8'h00, 1, 1, rd);
    check("wr_reg3", regs_o, 64'h0000_0000_4200_0000);
    check("model_reg3", {56'd0, model_regs[3]}, 64'h42);

    for (int t = 0; t < 40; t++) begin
      kind  = $urandom_range(0, 9);
      frame = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11)), 8'($urandom_range(0, 255))};
      if (kind < 2)       n = $urandom_range(1, 15);
      else if (kind == 2) n = $urandom_range(17, 24);
      else                n = 16;
      send_frame(frame, n, 8'($urandom_range(0, 255)), 1, 1, rd);
    end

    tick(10);
    check("all_commits_seen", 64'(cmd_rd), 64'(cmd_q.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
